// File: rtl/write_arb_pkg.sv
// Shared types and constants for the UART write-lock arbiter.
// Build option: WRITE_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package write_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_NTHREADS = 2;
    localparam int UART_BYTE_W  = 8;

endpackage

// File: rtl/uart_write_arbiter_rr_pick.sv
// Combinational picker: round-robin after 'last', or lowest index when
// WRITE_ARB_FIXED_PRIO_EN is defined.
module rr_pick
    import write_arb_pkg::*;
#(
    parameter int NTHREADS = DEF_NTHREADS,
    parameter int IDXW     = $clog2(NTHREADS)
) (
    input  logic [NTHREADS-1:0] req,
    input  logic [IDXW-1:0]     last,
    output logic [IDXW-1:0]     winner,
    output logic                any
);

    logic w_found;

    assign any = |req;

`ifdef WRITE_ARB_FIXED_PRIO_EN
    always_comb begin
        winner  = '0;
        w_found = 1'b0;
        for (int i = 0; i < NTHREADS; i++) begin
            if (!w_found && req[i]) begin
                winner  = IDXW'(i);
                w_found = 1'b1;
            end
        end
    end
`else
    // Search starts just past 'last', so the previous owner ranks lowest.
    always_comb begin
        int k;
        winner  = '0;
        w_found = 1'b0;
        k       = 0;
        for (int i = 1; i <= NTHREADS; i++) begin
            k = (int'(last) + i) % NTHREADS;
            if (!w_found && req[k]) begin
                winner  = IDXW'(k);
                w_found = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_write_arbiter.sv
// Shares one UART TX byte channel between NTHREADS threads via a lock handshake.
// Build option: WRITE_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module uart_write_arbiter
    import write_arb_pkg::*;
#(
    parameter int NTHREADS = DEF_NTHREADS,
    parameter int IDXW     = $clog2(NTHREADS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NTHREADS-1:0]             write_lock_req,
    output logic [NTHREADS-1:0]             write_lock_res,
    output logic [NTHREADS-1:0]             write_ready,
    input  logic [UART_BYTE_W*NTHREADS-1:0] write_data,
    input  logic [NTHREADS-1:0]             write_data_valid,
    output logic [UART_BYTE_W-1:0]          uart_data,
    output logic                            uart_data_valid,
    input  logic                            uart_ready,
    output logic                            busy,
    output logic [IDXW-1:0]                 owner
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [IDXW-1:0]       r_owner;
    logic [IDXW-1:0]       w_owner_nxt;
    logic [NTHREADS-1:0]   r_res;
    logic [NTHREADS-1:0]   w_res_nxt;
    logic [IDXW-1:0]       w_winner;
    logic                  w_any;
    logic [NTHREADS-1:0]   w_ready;
    logic [UART_BYTE_W-1:0] w_udata;
    logic                  w_uvalid;

    rr_pick #(
        .NTHREADS (NTHREADS),
        .IDXW     (IDXW)
    ) u_pick (
        .req    (write_lock_req),
        .last   (r_owner),
        .winner (w_winner),
        .any    (w_any)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_owner <= IDXW'(NTHREADS - 1);
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_res   <= w_res_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_res_nxt   = r_res;
        w_ready     = '0;
        w_udata     = '0;
        w_uvalid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_res_nxt = '0;
                if (w_any) begin
                    w_owner_nxt           = w_winner;
                    w_res_nxt[w_winner]   = 1'b1;
                    w_state_nxt           = GRANT;
                end
            end
            GRANT: begin
                w_ready[r_owner] = uart_ready;
                w_udata  = write_data[32'(r_owner)*UART_BYTE_W +: UART_BYTE_W];
                w_uvalid = write_data_valid[r_owner];
                if (!write_lock_req[r_owner]) begin
                    w_res_nxt   = '0;
                    w_state_nxt = RELEASE;
                end
            end
            // One dead cycle so the ex-owner sees res low before any re-grant.
            RELEASE: begin
                w_res_nxt   = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_res_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign write_lock_res  = r_res;
    assign write_ready     = w_ready;
    assign uart_data       = w_udata;
    assign uart_data_valid = w_uvalid;
    assign busy            = (r_state == GRANT);
    assign owner           = r_owner;

endmodule

// File: tb/tb_uart_write_arbiter.sv
// Directed self-checking bench for uart_write_arbiter (NTHREADS=2).
// Honours WRITE_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_uart_write_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  res;
    logic [1:0]  wready;
    logic [15:0] wdata;
    logic [1:0]  wvalid;
    logic [7:0]  udata;
    logic        uvalid;
    logic        uready;
    logic        busy;
    logic [0:0]  owner;

    int pass_cnt;
    int total_cnt;

    uart_write_arbiter #(.NTHREADS(2), .IDXW(1)) dut (
        .clock            (clock),
        .reset            (reset),
        .write_lock_req   (req),
        .write_lock_res   (res),
        .write_ready      (wready),
        .write_data       (wdata),
        .write_data_valid (wvalid),
        .uart_data        (udata),
        .uart_data_valid  (uvalid),
        .uart_ready       (uready),
        .busy             (busy),
        .owner            (owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1, "timeout");
    end

    // At most one grant bit may be high on any cycle.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            total_cnt++;
            if ($countones(res) > 1)
                $display("FAIL onehot_res: got %b want at most one bit", res);
            else
                pass_cnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        req    = 2'b00;
        wdata  = 16'h0000;
        wvalid = 2'b00;
        uready = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (res !== 2'b00) $display("FAIL rst_res: got %b want 00", res);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (owner !== 1'b1) $display("FAIL rst_owner: got %0d want 1", owner);
        else pass_cnt++;
        total_cnt++;
        if ({uvalid, udata} !== 9'h000)
            $display("FAIL rst_uart: got %b/%h want 0/00", uvalid, udata);
        else pass_cnt++;
        total_cnt++;
        if (wready !== 2'b00) $display("FAIL rst_wready: got %b want 00", wready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        reset = 1'b1;
        req   = 2'b01;
        tick();
        total_cnt++;
        if ({res, busy, owner} !== {2'b01, 1'b1, 1'b0})
            $display("FAIL basic_grant: got res=%b busy=%b own=%0d want 01/1/0",
                     res, busy, owner);
        else pass_cnt++;
        req = 2'b00;
        tick();
        total_cnt++;
        if ({res, busy} !== {2'b00, 1'b0})
            $display("FAIL basic_release: got res=%b busy=%b want 00/0", res, busy);
        else pass_cnt++;
        req = 2'b01;
        tick();
        total_cnt++;
        if (res !== 2'b00) $display("FAIL basic_deadtime: got %b want 00", res);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (res !== 2'b01) $display("FAIL basic_regrant: got %b want 01", res);
        else pass_cnt++;
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_alternate();
        int exp_w [4];
        int w;
`ifdef WRITE_ARB_FIXED_PRIO_EN
        exp_w = '{0, 0, 0, 0};
`else
        exp_w = '{1, 0, 1, 0};
`endif
        req    = 2'b11;
        uready = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int t = 0; t < 4 && res == 2'b00; t++) tick();
            w = exp_w[g];
            total_cnt++;
            if (res !== 2'(1 << w) || owner !== 1'(w))
                $display("FAIL alt_grant%0d: got res=%b own=%0d want res=%b own=%0d",
                         g, res, owner, 2'(1 << w), w);
            else pass_cnt++;
            for (int b = 0; b < 6; b++) begin
                wdata  = {8'h20 + 8'(b), 8'h10 + 8'(b)};
                wvalid = 2'(1 << w);
                #1;
                if (b == 2) begin
                    total_cnt++;
                    if ({uvalid, udata} !== {1'b1, wdata[8*w +: 8]})
                        $display("FAIL alt_data%0d: got %b/%h want 1/%h",
                                 g, uvalid, udata, wdata[8*w +: 8]);
                    else pass_cnt++;
                end
                tick();
            end
            wvalid = 2'b00;
            req[w] = 1'b0;
            if (g == 3) req = 2'b00;
            tick();
            total_cnt++;
            if (res !== 2'b00) $display("FAIL alt_rel%0d: got %b want 00", g, res);
            else pass_cnt++;
            if (g < 3) req[w] = 1'b1;
            tick();
        end
    endtask

    task automatic test_data_mux();
        req = 2'b10;
        tick();
        total_cnt++;
        if ({res, owner} !== {2'b10, 1'b1})
            $display("FAIL mux_grant: got res=%b own=%0d want 10/1", res, owner);
        else pass_cnt++;
        wdata  = {8'hA5, 8'h3C};
        wvalid = 2'b11;
        uready = 1'b1;
        #1;
        total_cnt++;
        if ({uvalid, udata} !== {1'b1, 8'hA5})
            $display("FAIL mux_data: got %b/%h want 1/a5", uvalid, udata);
        else pass_cnt++;
        total_cnt++;
        if (wready !== 2'b10) $display("FAIL mux_wready: got %b want 10", wready);
        else pass_cnt++;
        wvalid = 2'b01;
        #1;
        total_cnt++;
        if (uvalid !== 1'b0) $display("FAIL mux_nonowner: got %b want 0", uvalid);
        else pass_cnt++;
    endtask

    task automatic test_ready_gate();
        uready = 1'b0;
        #1;
        total_cnt++;
        if (wready !== 2'b00) $display("FAIL gate_low: got %b want 00", wready);
        else pass_cnt++;
        uready = 1'b1;
        #1;
        total_cnt++;
        if (wready !== 2'b10) $display("FAIL gate_high: got %b want 10", wready);
        else pass_cnt++;
        req = 2'b11;
        tick();
        tick();
        total_cnt++;
        if ({res, busy} !== {2'b10, 1'b1})
            $display("FAIL gate_hold: got res=%b busy=%b want 10/1", res, busy);
        else pass_cnt++;
    endtask

    task automatic test_reraise();
        req = 2'b01;
        tick();
        total_cnt++;
        if (res !== 2'b00) $display("FAIL rr_release: got %b want 00", res);
        else pass_cnt++;
        req = 2'b11;
        tick();
        tick();
        total_cnt++;
        if ({res, owner} !== {2'b01, 1'b0})
            $display("FAIL rr_reraise: got res=%b own=%0d want 01/0", res, owner);
        else pass_cnt++;
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_short_grant();
        req = 2'b10;
        tick();
        total_cnt++;
        if (res !== 2'b10) $display("FAIL short_grant: got %b want 10", res);
        else pass_cnt++;
        req = 2'b00;
        tick();
        total_cnt++;
        if ({res, busy} !== {2'b00, 1'b0})
            $display("FAIL short_drop: got res=%b busy=%b want 00/0", res, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (res !== 2'b00) $display("FAIL short_idle: got %b want 00", res);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_grant();
        req = 2'b01;
        tick();
        total_cnt++;
        if ({res, owner} !== {2'b01, 1'b0})
            $display("FAIL mid_pre: got res=%b own=%0d want 01/0", res, owner);
        else pass_cnt++;
        wvalid = 2'b11;
        reset  = 1'b0;
        req    = 2'b00;
        tick();
        total_cnt++;
        if ({res, uvalid, busy, owner} !== {2'b00, 1'b0, 1'b0, 1'b1})
            $display("FAIL mid_reset: got res=%b uv=%b busy=%b own=%0d want 00/0/0/1",
                     res, uvalid, busy, owner);
        else pass_cnt++;
        reset = 1'b1;
        req   = 2'b10;
        tick();
        total_cnt++;
        if ({res, owner} !== {2'b10, 1'b1})
            $display("FAIL mid_regrant: got res=%b own=%0d want 10/1", res, owner);
        else pass_cnt++;
        req    = 2'b00;
        wvalid = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_alternate();
        test_data_mux();
        test_ready_gate();
        test_reraise();
        test_short_grant();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_write_arbiter.md
Name: uart_write_arbiter

Overview:
- Shares the single UART transmit byte channel between NTHREADS thread instances.
- Implements the write lock handshake that each thread's WRITE instruction uses: write_lock_req → write_lock_res, then write_ready / write_data / write_data_valid.
- Grants one owner at a time, round-robin by default. Forwards only the owner's byte stream to the UART TX front end and gates write_ready to the owner.
- Sits between the thread array and the UART TX module.

Parameters:
- NTHREADS, 2, number of requesting threads (≥2).
- IDXW, $clog2(NTHREADS), width of the owner index.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- write_lock_req  in  NTHREADS  per-thread lock request, level.
- write_lock_res  out  NTHREADS  per-thread lock grant, level, registered.
- write_ready  out  NTHREADS  per-thread ready; owner only.
- write_data  in  8*NTHREADS  flattened per-thread byte; thread i at [8i+:8].
- write_data_valid  in  NTHREADS  per-thread byte valid.
- uart_data  out  8  byte to UART TX.
- uart_data_valid  out  1  byte strobe to UART TX.
- uart_ready  in  1  UART TX can accept a byte.
- busy  out  1  lock currently held (state GRANT).
- owner  out  IDXW  index of current or last owner.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; write_lock_res=0; owner=NTHREADS-1, so thread 0 wins first.
  - busy=0; uart_data=0; uart_data_valid=0; write_ready=0.
  - Reset mid-GRANT drops the grant immediately. The partially sent UART frame is abandoned.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any write_lock_req is set, the winner is the first set bit searching from owner+1 upward, wrapping modulo NTHREADS.
  - Register owner=winner, write_lock_res[winner]=1, go to GRANT.
  - Latency from req to res is 1 cycle when uncontested.
  - If no req, stay in IDLE.
- GRANT:
  - write_ready[owner] = uart_ready; all other write_ready = 0 (combinational).
  - uart_data = write_data[owner]; uart_data_valid = write_data_valid[owner] (combinational mux).
  - valid/data from non-owners are ignored.
  - If write_lock_req[owner]==0, clear write_lock_res[owner] and go to RELEASE.
- RELEASE:
  - All res=0; uart_data_valid=0.
  - Unconditional 1-cycle dead time, then go to IDLE.
  - This guarantees the released thread observes res low before any re-grant.
- Outside GRANT: uart_data_valid=0, uart_data=0, all write_ready=0.
- Boundary conditions:
  - At most one res bit is ever high.
  - A req dropped in IDLE before being granted loses nothing; no grant is issued.
  - If the owner's req falls on the same cycle that GRANT is entered, the grant still lasts exactly one cycle, then RELEASE.
  - A req held continuously by the owner keeps the lock indefinitely; there is no preemption.
  - The ex-owner re-requesting in RELEASE is evaluated in IDLE with the lowest round-robin priority.
  - Minimum gap between consecutive grants: 2 cycles (RELEASE + IDLE).
- owner is updated only in IDLE on a grant.

Optional Feature:
- Macro: WRITE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index requesting thread always wins in IDLE and the owner pointer is ignored for arbitration. owner still reports the granted index.
- Undefined (default): round-robin as specified above.
- Ports and timing are identical in both builds.

Decomposition:
- Package write_arb_pkg:
  - state enum (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2).
  - default NTHREADS.
  - UART byte width constant (8).
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NTHREADS], last[IDXW].
  - Outputs: winner[IDXW], any.
  - Contains the fixed-priority path under WRITE_ARB_FIXED_PRIO_EN.

Test Plan:
- Reset release, req=2'b01 at cycle 0 → res=2'b01 at cycle 1, busy=1, owner=0; drop req → res=0 next cycle, busy=0, RELEASE for 1 cycle.
- req=2'b11 held by both, each releasing after 6 bytes → grants alternate 0,1,0,1 (default build); with WRITE_ARB_FIXED_PRIO_EN, thread 0 wins every contention.
- Owner 1 drives data 0xA5 valid=1 with uart_ready=1 → uart_data=0xA5 and uart_data_valid=1 in the same cycle; thread 0 simultaneously drives 0x3C valid=1 → never appears on uart_data; write_ready=2'b10.
- uart_ready=0 during GRANT → write_ready[owner]=0; toggle uart_ready → write_ready follows combinationally.
- Assert reset mid-GRANT → next cycle res=0, uart_data_valid=0, owner=NTHREADS-1; after deassert with req=2'b10 → thread 1 granted within 1 cycle.
- Owner drops req and re-raises it in RELEASE while thread 0 also requests → thread 0 granted first.
